// File: rtl/cov_pattern_seq.sv
// Coverage stimulus block: all-ones/pattern detectors with saturating hit counters
// and a programmable-period step sequencer. Define COV_STICKY_EN to build the sticky seen_* flags.
module cov_pattern_seq #(
    parameter int              IN_W    = 3,
    parameter logic [IN_W-1:0] PATTERN = 3'b110,
    parameter int              PERIOD  = 3,
    parameter int              CNT_W   = 8,
    localparam int             STEP_W  = $clog2(PERIOD)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [IN_W-1:0]   in_vec,
    input  logic              cnt_en,
    input  logic              cnt_clr,
    input  logic              seq_en,
    input  logic              seq_restart,
    output logic              out_all,
    output logic              out_pat,
    output logic [STEP_W-1:0] seq_step,
    output logic              seq_pulse,
    output logic [CNT_W-1:0]  cnt_all,
    output logic [CNT_W-1:0]  cnt_pat,
    output logic [CNT_W-1:0]  cnt_wrap,
    output logic              seen_all,
    output logic              seen_pat
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [STEP_W-1:0] step_nxt;
    logic              pulse_nxt;

    assign out_all = &in_vec;
    assign out_pat = (in_vec == PATTERN);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        step_nxt  = seq_step;
        pulse_nxt = 1'b0;
        if (seq_restart) begin
            step_nxt = '0;
        end else if (seq_en && seq_step == LAST_STEP) begin
            step_nxt  = '0;
            pulse_nxt = 1'b1;
        end else if (seq_en) begin
            // Unreachable codes above LAST_STEP also increment and wrap at 2^STEP_W.
            step_nxt = seq_step + STEP_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            seq_step  <= '0;
            seq_pulse <= 1'b0;
        end else begin
            seq_step  <= step_nxt;
            seq_pulse <= pulse_nxt;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_all  <= '0;
            cnt_pat  <= '0;
            cnt_wrap <= '0;
        end else if (cnt_clr) begin
            cnt_all  <= '0;
            cnt_pat  <= '0;
            cnt_wrap <= '0;
        end else begin
            if (cnt_en && out_all && cnt_all != CNT_MAX)
                cnt_all <= cnt_all + CNT_W'(1);
            if (cnt_en && out_pat && cnt_pat != CNT_MAX)
                cnt_pat <= cnt_pat + CNT_W'(1);
            if (seq_pulse && cnt_wrap != CNT_MAX)
                cnt_wrap <= cnt_wrap + CNT_W'(1);
        end
    end

`ifdef COV_STICKY_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            seen_all <= 1'b0;
            seen_pat <= 1'b0;
        end else if (cnt_clr) begin
            seen_all <= 1'b0;
            seen_pat <= 1'b0;
        end else begin
            if (cnt_en && out_all) seen_all <= 1'b1;
            if (cnt_en && out_pat) seen_pat <= 1'b1;
        end
    end
`else
    assign seen_all = 1'b0;
    assign seen_pat = 1'b0;
`endif

endmodule

// File: tb/tb_cov_pattern_seq.sv
// Directed bench for cov_pattern_seq: default instance plus a CNT_W=4, PATTERN=3'b111 instance.
module tb_cov_pattern_seq;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [2:0] in_vec = 3'b000;
    logic       cnt_en = 1'b0, cnt_clr = 1'b0, seq_en = 1'b0, seq_restart = 1'b0;

    logic       out_all, out_pat, seq_pulse, seen_all, seen_pat;
    logic [1:0] seq_step;
    logic [7:0] cnt_all, cnt_pat, cnt_wrap;

    logic       s_out_all, s_out_pat, s_seq_pulse, s_seen_all, s_seen_pat;
    logic [1:0] s_seq_step;
    logic [3:0] s_cnt_all, s_cnt_pat, s_cnt_wrap;

    int checks = 0;
    int failures = 0;

`ifdef COV_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    always #5 CLK = ~CLK;

    cov_pattern_seq dut (
        .CLK(CLK), .RST(RST), .in_vec(in_vec), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
        .seq_en(seq_en), .seq_restart(seq_restart), .out_all(out_all), .out_pat(out_pat),
        .seq_step(seq_step), .seq_pulse(seq_pulse), .cnt_all(cnt_all), .cnt_pat(cnt_pat),
        .cnt_wrap(cnt_wrap), .seen_all(seen_all), .seen_pat(seen_pat)
    );

    cov_pattern_seq #(.PATTERN(3'b111), .CNT_W(4)) u_sat (
        .CLK(CLK), .RST(RST), .in_vec(in_vec), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
        .seq_en(seq_en), .seq_restart(seq_restart), .out_all(s_out_all), .out_pat(s_out_pat),
        .seq_step(s_seq_step), .seq_pulse(s_seq_pulse), .cnt_all(s_cnt_all), .cnt_pat(s_cnt_pat),
        .cnt_wrap(s_cnt_wrap), .seen_all(s_seen_all), .seen_pat(s_seen_pat)
    );

    typedef struct {
        logic [2:0] vec;
        logic       exp_all;
        logic       exp_pat;
        logic       exp_sat_pat;
    } det_vec_t;

    det_vec_t det_tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge and are observed there too.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #3;
        RST = 1'b0;
    endtask

    // Step codes at or above PERIOD must never appear.
    always @(negedge CLK) begin
        if (!RST && seq_step >= 2'd3) begin
            failures++;
            $display("FAIL step_range: seq_step=%0d", seq_step);
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            det_tbl[i].vec         = 3'(i);
            det_tbl[i].exp_all     = (i == 7);
            det_tbl[i].exp_pat     = (i == 6);
            det_tbl[i].exp_sat_pat = (i == 7);
        end

        // Reset state; detectors stay live during reset.
        in_vec = 3'b111;
        #1;
        check("rst_out_all", 32'(out_all), 32'd1);
        check("rst_seq_step", 32'(seq_step), 32'd0);
        check("rst_seq_pulse", 32'(seq_pulse), 32'd0);
        check("rst_cnt_all", 32'(cnt_all), 32'd0);
        check("rst_cnt_wrap", 32'(cnt_wrap), 32'd0);
        #11;
        RST = 1'b0;
        tick();
        check("rst_cnt_all_idle", 32'(cnt_all), 32'd0);

        // Detector sweep with counting.
        cnt_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_vec = det_tbl[i].vec;
            #1;
            check($sformatf("out_all[%0d]", i), 32'(out_all), 32'(det_tbl[i].exp_all));
            check($sformatf("out_pat[%0d]", i), 32'(out_pat), 32'(det_tbl[i].exp_pat));
            check($sformatf("sat_out_pat[%0d]", i), 32'(s_out_pat), 32'(det_tbl[i].exp_sat_pat));
            tick();
        end
        cnt_en = 1'b0;
        check("sweep_cnt_all", 32'(cnt_all), 32'd1);
        check("sweep_cnt_pat", 32'(cnt_pat), 32'd1);
        check("sweep_sat_cnt_pat", 32'(s_cnt_pat), 32'd1);
        check("sweep_seen_pat", 32'(seen_pat), 32'(STICKY));
        in_vec = 3'b111;
        tick();
        check("hold_cnt_all", 32'(cnt_all), 32'd1);

        // Free-running sequencer, 9 cycles after reset.
        do_reset();
        in_vec = 3'b000;
        seq_en = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            check($sformatf("seq_step[%0d]", c), 32'(seq_step), 32'(c % 3));
            check($sformatf("seq_pulse[%0d]", c), 32'(seq_pulse), 32'(c % 3 == 0));
            check($sformatf("cnt_wrap[%0d]", c), 32'(cnt_wrap), 32'((c - 1) / 3));
        end
        seq_en = 1'b0;
        tick();
        check("wrap_final", 32'(cnt_wrap), 32'd3);
        check("pulse_off", 32'(seq_pulse), 32'd0);

        // Freeze and resume.
        seq_en = 1'b1; tick();
        seq_en = 1'b0; tick(); tick();
        check("freeze_step", 32'(seq_step), 32'd1);
        seq_en = 1'b1; tick();
        check("resume_step", 32'(seq_step), 32'd2);

        // Restart wins over the wrap at step 2.
        seq_restart = 1'b1;
        tick();
        seq_restart = 1'b0;
        seq_en = 1'b0;
        check("restart_step", 32'(seq_step), 32'd0);
        check("restart_pulse", 32'(seq_pulse), 32'd0);
        tick();
        check("restart_wrap", 32'(cnt_wrap), 32'd3);

        // Saturation on the 4-bit instance, then clear beats a same-cycle hit.
        in_vec = 3'b111;
        cnt_en = 1'b1;
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("sat_cnt_all", 32'(s_cnt_all), 32'd15);
        check("wide_cnt_all", 32'(cnt_all), 32'd20);
        check("sat_seen_all", 32'(seen_all), 32'(STICKY));
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        cnt_en = 1'b0;
        check("clr_sat_cnt_all", 32'(s_cnt_all), 32'd0);
        check("clr_cnt_all", 32'(cnt_all), 32'd0);
        check("clr_cnt_wrap", 32'(cnt_wrap), 32'd0);
        check("clr_seen_all", 32'(seen_all), 32'd0);

        // Asynchronous reset mid-cycle with live state.
        in_vec = 3'b110;
        cnt_en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        seq_en = 1'b1;
        tick();
        cnt_en = 1'b0;
        seq_en = 1'b0;
        check("pre_rst_cnt_pat", 32'(cnt_pat), 32'd5);
        check("pre_rst_step", 32'(seq_step), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        check("async_step", 32'(seq_step), 32'd0);
        check("async_cnt_pat", 32'(cnt_pat), 32'd0);
        check("async_seen_pat", 32'(seen_pat), 32'd0);
        #5;
        RST = 1'b0;
        tick();
        check("post_rst_pulse", 32'(seq_pulse), 32'd0);
        check("post_rst_step", 32'(seq_step), 32'd0);
        check("post_rst_wrap", 32'(cnt_wrap), 32'd0);

        // Sticky pattern flag: one hit, then idle, then clear.
        in_vec = 3'b110;
        cnt_en = 1'b1;
        tick();
        cnt_en = 1'b0;
        in_vec = 3'b000;
        tick(); tick();
        check("sticky_seen_pat", 32'(seen_pat), 32'(STICKY));
        check("sticky_seen_all", 32'(seen_all), 32'd0);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("sticky_clr_pat", 32'(seen_pat), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
